hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - MIPS Decode hazard scoreboard with forwarding selects and mult/div busy stall.
// Define HAZ_STAT_EN to add the stall_cnt / md_stall_cnt statistics outputs.
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int SW       = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [4:0]    d_r_use1,
  input  logic [4:0]    d_r_use2,
  input  logic [TW-1:0] d_t_use1,
  input  logic [TW-1:0] d_t_use2,
  input  logic [4:0]    d_r_new,
  input  logic [TW-1:0] d_t_new,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  output logic          stall,
  output logic [SW-1:0] fwd_sel1,
  output logic [SW-1:0] fwd_sel2,
  output logic          md_busy
`ifdef HAZ_STAT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   md_stall_cnt
`endif
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic [STAGES-1:0] sb_valid;
  logic [4:0]        sb_rnew [STAGES];
  logic [TW-1:0]     sb_tnew [STAGES];
  logic [CW-1:0]     md_cnt;

  logic [4:0]        use_r [2];
  logic [TW-1:0]     use_t [2];
  logic              hit   [2];
  logic [TW-1:0]     hit_t [2];
  logic [SW-1:0]     hit_sel [2];
  logic              haz   [2];
  logic [SW-1:0]     sel   [2];

  assign use_r[0] = d_r_use1;
  assign use_r[1] = d_r_use2;
  assign use_t[0] = d_t_use1;
  assign use_t[1] = d_t_use2;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      hit[n]     = 1'b0;
      hit_t[n]   = '0;
      hit_sel[n] = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (sb_valid[i] && (sb_rnew[i] == use_r[n])) begin
          hit[n]     = 1'b1;
          hit_t[n]   = sb_tnew[i];
          hit_sel[n] = SW'(i + 1);
        end
      end
      if (use_r[n] == 5'd0) begin
        hit[n] = 1'b0;
      end
      haz[n] = hit[n] && (hit_t[n] > use_t[n]);
      sel[n] = (d_valid && hit[n] && (hit_t[n] == '0)) ? hit_sel[n] : '0;
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign stall    = d_valid & (haz[0] | haz[1] | (d_md_use & md_busy));
  assign fwd_sel1 = sel[0];
  assign fwd_sel2 = sel[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        sb_rnew[i] <= '0;
        sb_tnew[i] <= '0;
      end
      md_cnt <= '0;
    end else begin
      sb_valid[0] <= d_valid & ~stall & (d_r_new != 5'd0);
      sb_rnew[0]  <= d_r_new;
      sb_tnew[0]  <= d_t_new;
      for (int i = 1; i < STAGES; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rnew[i]  <= sb_rnew[i-1];
        sb_tnew[i]  <= (sb_tnew[i-1] == '0) ? '0 : sb_tnew[i-1] - TW'(1);
      end
      // A start held by a busy unit stalls, so the counter is never reloaded mid-operation.
      if (d_valid && !stall && d_md_start) begin
        md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

`ifdef HAZ_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
      if (!haz[0] && !haz[1]) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
